// File: rtl/rv_pkg.sv
// Shared RV64 memory-access definitions: funct3 encodings, LSU states, fault codes
// and the decode checks the load/store unit applies at accept time.
package rv_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110
  } load_f3_t;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010,
    F3_SD = 3'b011
  } store_f3_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_t;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

  // Both control flags together, load funct3 111 and any store funct3 1xx are illegal.
  function automatic logic is_illegal(input logic rd, input logic wr, input logic [2:0] f3);
    if (rd && wr) return 1'b1;
    if (rd) return f3 == 3'b111;
    return f3[2];
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] off);
    case (f3[1:0])
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      2'd3:    return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: store byte enables and lane shift,
// load extract with sign or zero extension.
module lsu_align
  import rv_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [2:0]  st_off,
  input  logic [63:0] st_data,
  output logic [7:0]  st_be,
  output logic [63:0] st_lane,
  input  logic [2:0]  ld_funct3,
  input  logic [2:0]  ld_off,
  input  logic [63:0] ld_raw,
  output logic [63:0] ld_data
);

  logic [7:0]  st_mask;
  logic [63:0] ld_shift;
  logic        ld_sign;

  always_comb begin
    // NOTE: default assigned before the case so no path leaves st_mask unassigned (no latch).
    st_mask = 8'h01;
    case (store_f3_t'({1'b0, st_funct3[1:0]}))
      F3_SH:   st_mask = 8'h03;
      F3_SW:   st_mask = 8'h0F;
      F3_SD:   st_mask = 8'hFF;
      default: st_mask = 8'h01;
    endcase
  end

  assign st_be    = st_mask << st_off;
  assign st_lane  = st_data << {st_off, 3'b000};
  assign ld_shift = ld_raw >> {ld_off, 3'b000};
  assign ld_sign  = ~ld_funct3[2];

  always_comb begin
    ld_data = ld_shift;
    case (load_f3_t'({1'b0, ld_funct3[1:0]}))
      F3_LB:   ld_data = {{56{ld_sign & ld_shift[7]}}, ld_shift[7:0]};
      F3_LH:   ld_data = {{48{ld_sign & ld_shift[15]}}, ld_shift[15:0]};
      F3_LW:   ld_data = {{32{ld_sign & ld_shift[31]}}, ld_shift[31:0]};
      default: ld_data = ld_shift;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV64 memory-stage load/store unit: one operation at a time over a req/gnt/rvalid
// data bus, returning extended load data or a fault code to writeback.
module load_store_unit
  import rv_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_mem_to_reg,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [63:0]       in_wdata,
  input  logic [4:0]        in_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_be,
  output logic [63:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [63:0]       mem_rdata,
  output logic              wb_valid,
  output logic [63:0]       wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_we,
  output logic [1:0]        wb_fault,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  lsu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             op_load;
  logic             op_to_reg;
  logic [4:0]       op_rd;
  logic [2:0]       op_f3;
  logic [2:0]       op_off;

  logic             accept;
  logic             bad_op;
  logic             bad_align;
  logic [7:0]       st_be;
  logic [63:0]      st_lane;
  logic [63:0]      ld_data;

  assign accept    = in_valid && (state == IDLE) && (in_mem_read || in_mem_write);
  assign bad_op    = is_illegal(in_mem_read, in_mem_write, in_funct3);
  assign bad_align = is_misaligned(in_funct3, in_addr[2:0]);
  assign in_ready  = (state == IDLE);
  assign busy      = ~in_ready;

  // Store steering uses the incoming operation; load extraction uses the latched one.
  lsu_align u_align (
    .st_funct3 (in_funct3),
    .st_off    (in_addr[2:0]),
    .st_data   (in_wdata),
    .st_be     (st_be),
    .st_lane   (st_lane),
    .ld_funct3 (op_f3),
    .ld_off    (op_off),
    .ld_raw    (mem_rdata),
    .ld_data   (ld_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_load   <= 1'b0;
      op_to_reg <= 1'b0;
      op_rd     <= '0;
      op_f3     <= '0;
      op_off    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_data   <= '0;
      wb_rd     <= '0;
      wb_we     <= 1'b0;
      wb_fault  <= FAULT_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_load   <= in_mem_read;
            op_to_reg <= in_mem_to_reg;
            op_rd     <= in_rd;
            op_f3     <= in_funct3;
            op_off    <= in_addr[2:0];
            mem_we    <= in_mem_write;
            mem_addr  <= {in_addr[ADDR_W-1:3], 3'b000};
            mem_be    <= st_be;
            mem_wdata <= st_lane;
            if (bad_op || bad_align) begin
              state    <= DONE;
              wb_valid <= 1'b1;
              wb_data  <= '0;
              wb_we    <= 1'b0;
              wb_rd    <= in_rd;
              wb_fault <= bad_op ? FAULT_ILLEGAL : FAULT_MISALIGN;
            end else begin
              state   <= REQ;
              mem_req <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            state   <= WAIT;
            mem_req <= 1'b0;
            cnt     <= '0;
          end
        end
        WAIT: begin
          // A response in the final counted cycle still beats the timeout.
          if (mem_rvalid) begin
            state    <= DONE;
            wb_valid <= 1'b1;
            wb_data  <= op_load ? ld_data : 64'd0;
            wb_we    <= op_to_reg;
            wb_rd    <= op_rd;
            wb_fault <= FAULT_NONE;
          end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
            state    <= DONE;
            wb_valid <= 1'b1;
            wb_data  <= '0;
            wb_we    <= 1'b0;
            wb_rd    <= op_rd;
            wb_fault <= FAULT_TIMEOUT;
          end else if (TIMEOUT != 0) begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          wb_valid <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stimulus pushes expected writeback results into
// a scoreboard queue, an independent monitor pops and compares on every wb_valid.
module tb_load_store_unit;
  import rv_pkg::*;

  localparam int ADDR_W = 32;
  localparam int TMO    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic        in_mem_read = 1'b0, in_mem_write = 1'b0, in_mem_to_reg = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_addr = '0;
  logic [63:0] in_wdata = '0;
  logic [4:0]  in_rd = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_be;
  logic [63:0] mem_wdata;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        wb_valid, wb_we, busy;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_fault;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        we;
    logic [1:0]  fault;
  } exp_t;

  exp_t sb_q[$];

  load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_mem_to_reg(in_mem_to_reg),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we),
    .wb_fault(wb_fault), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every writeback pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && wb_valid) begin
      if (sb_q.size() == 0) begin
        check("wb_unexpected", {63'd0, wb_valid}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("wb_data", wb_data, e.data);
        check("wb_rd", 64'(wb_rd), 64'(e.rd));
        check("wb_we", 64'(wb_we), 64'(e.we));
        check("wb_fault", 64'(wb_fault), 64'(e.fault));
      end
    end
  end

  task automatic issue(input logic rd_f, input logic wr_f, input logic to_reg,
                       input logic [2:0] f3, input logic [31:0] addr,
                       input logic [63:0] wd, input logic [4:0] rd);
    @(negedge clk);
    in_valid      = 1'b1;
    in_mem_read   = rd_f;
    in_mem_write  = wr_f;
    in_mem_to_reg = to_reg;
    in_funct3     = f3;
    in_addr       = addr;
    in_wdata      = wd;
    in_rd         = rd;
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    in_mem_read  = 1'b0;
    in_mem_write = 1'b0;
  endtask

  // Cycle 0 is the accept cycle; masks select the cycles that see gnt / rvalid.
  task automatic run_op(input string name, input logic rd_f, input logic wr_f,
                        input logic to_reg, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [63:0] wd, input logic [4:0] rd,
                        input logic [31:0] gnt_mask, input logic [31:0] rv_mask,
                        input logic [63:0] rdata, input logic [63:0] exp_data,
                        input logic [1:0] exp_fault, input int exp_lat,
                        input logic [7:0] exp_be, input logic [63:0] exp_wd);
    exp_t e;
    logic exp_req;
    bit   seen;
    exp_req = (exp_fault == FAULT_NONE) || (exp_fault == FAULT_TIMEOUT);
    e.data  = exp_data;
    e.rd    = rd;
    e.we    = to_reg && (exp_fault == FAULT_NONE);
    e.fault = exp_fault;
    sb_q.push_back(e);
    issue(rd_f, wr_f, to_reg, f3, addr, wd, rd);
    seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check({name, "_req"}, 64'(mem_req), 64'(exp_req));
        if (exp_req) begin
          check({name, "_be"}, 64'(mem_be), 64'(exp_be));
          check({name, "_wdata"}, mem_wdata, exp_wd);
          check({name, "_addr"}, 64'(mem_addr), 64'(addr & 32'hFFFF_FFF8));
          check({name, "_we"}, 64'(mem_we), 64'(wr_f));
        end
      end
      if (wb_valid) begin
        seen = 1'b1;
        check({name, "_latency"}, 64'(c), 64'(exp_lat));
      end else begin
        mem_gnt    = (c < 32) ? gnt_mask[c] : 1'b0;
        mem_rvalid = (c < 32) ? rv_mask[c] : 1'b0;
        mem_rdata  = rdata;
      end
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if (!seen) check({name, "_wb_missing"}, 64'd0, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_be", 64'(mem_be), 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_wb_data", wb_data, 64'd0);
    check("rst_wb_fault", 64'(wb_fault), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // name rd wr to_reg f3 addr wdata rd gnt rv rdata | exp_data fault lat be wdata
    run_op("ld",   1, 0, 1, 3'b011, 32'h100, 64'h0, 5'd5, 32'h2, 32'h8,
           64'h1122334455667788, 64'h1122334455667788, FAULT_NONE, 4, 8'hFF, 64'h0);
    run_op("lb",   1, 0, 1, 3'b000, 32'h103, 64'h0, 5'd6, 32'h2, 32'h4,
           64'hAABBCCDD80223344, 64'hFFFFFFFFFFFFFF80, FAULT_NONE, 3, 8'h08, 64'h0);
    run_op("lbu",  1, 0, 1, 3'b100, 32'h103, 64'h0, 5'd7, 32'h2, 32'h4,
           64'hAABBCCDD80223344, 64'h0000000000000080, FAULT_NONE, 3, 8'h08, 64'h0);
    run_op("sh",   0, 1, 0, 3'b001, 32'h106, 64'hBEEF, 5'd0, 32'h4, 32'h10,
           64'h0, 64'h0, FAULT_NONE, 5, 8'hC0, 64'hBEEF000000000000);
    run_op("lw",   1, 0, 1, 3'b010, 32'h104, 64'h0, 5'd8, 32'h2, 32'h4,
           64'h8000000112345678, 64'hFFFFFFFF80000001, FAULT_NONE, 3, 8'hF0, 64'h0);
    run_op("lwu",  1, 0, 1, 3'b110, 32'h104, 64'h0, 5'd9, 32'h2, 32'h4,
           64'h8000000112345678, 64'h0000000080000001, FAULT_NONE, 3, 8'hF0, 64'h0);
    run_op("lh",   1, 0, 1, 3'b001, 32'h106, 64'h0, 5'd10, 32'h2, 32'h4,
           64'hF00D000000000000, 64'hFFFFFFFFFFFFF00D, FAULT_NONE, 3, 8'hC0, 64'h0);
    run_op("lhu",  1, 0, 1, 3'b101, 32'h106, 64'h0, 5'd11, 32'h2, 32'h4,
           64'hF00D000000000000, 64'h000000000000F00D, FAULT_NONE, 3, 8'hC0, 64'h0);
    run_op("sd",   0, 1, 0, 3'b011, 32'h108, 64'h0123456789ABCDEF, 5'd0, 32'h2, 32'h4,
           64'h0, 64'h0, FAULT_NONE, 3, 8'hFF, 64'h0123456789ABCDEF);
    run_op("sb",   0, 1, 0, 3'b000, 32'h10D, 64'hA5, 5'd0, 32'h2, 32'h4,
           64'h0, 64'h0, FAULT_NONE, 3, 8'h20, 64'h0000A50000000000);

    run_op("lw_mis", 1, 0, 1, 3'b010, 32'h102, 64'h0, 5'd12, 32'h0, 32'h0,
           64'h0, 64'h0, FAULT_MISALIGN, 1, 8'h0, 64'h0);
    run_op("sw_mis", 0, 1, 0, 3'b010, 32'h10A, 64'h0, 5'd0, 32'h0, 32'h0,
           64'h0, 64'h0, FAULT_MISALIGN, 1, 8'h0, 64'h0);
    run_op("ld_f3_111", 1, 0, 1, 3'b111, 32'h100, 64'h0, 5'd13, 32'h0, 32'h0,
           64'h0, 64'h0, FAULT_ILLEGAL, 1, 8'h0, 64'h0);
    run_op("st_f3_1xx", 0, 1, 0, 3'b100, 32'h100, 64'h0, 5'd0, 32'h0, 32'h0,
           64'h0, 64'h0, FAULT_ILLEGAL, 1, 8'h0, 64'h0);
    run_op("both_flags", 1, 1, 1, 3'b011, 32'h100, 64'h0, 5'd14, 32'h0, 32'h0,
           64'h0, 64'h0, FAULT_ILLEGAL, 1, 8'h0, 64'h0);

    // rvalid alongside gnt in cycle 1 is ignored; the cycle-3 response completes it.
    run_op("rv_with_gnt", 1, 0, 1, 3'b011, 32'h110, 64'h0, 5'd15, 32'h2, 32'hA,
           64'hCAFEF00DDEADBEEF, 64'hCAFEF00DDEADBEEF, FAULT_NONE, 4, 8'hFF, 64'h0);

    // Timeout of 4: WAIT spans cycles 2..5, so a cycle-5 response still wins.
    run_op("rv_wait3", 1, 0, 1, 3'b011, 32'h118, 64'h0, 5'd16, 32'h2, 32'h10,
           64'h55AA55AA55AA55AA, 64'h55AA55AA55AA55AA, FAULT_NONE, 5, 8'hFF, 64'h0);
    run_op("rv_at_limit", 1, 0, 1, 3'b011, 32'h118, 64'h0, 5'd17, 32'h2, 32'h20,
           64'h0F0F0F0F0F0F0F0F, 64'h0F0F0F0F0F0F0F0F, FAULT_NONE, 6, 8'hFF, 64'h0);
    run_op("timeout", 1, 0, 1, 3'b011, 32'h120, 64'h0, 5'd18, 32'h2, 32'h0,
           64'h0, 64'h0, FAULT_TIMEOUT, 6, 8'hFF, 64'h0);

    // Late response after the timeout is dropped.
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hDEAD;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("late_rv_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("late_rv_no_req", 64'(mem_req), 64'd0);

    // Neither control flag: the operation is ignored.
    @(negedge clk);
    in_valid = 1'b1;
    in_funct3 = 3'b011;
    in_addr = 32'h100;
    @(negedge clk);
    in_valid = 1'b0;
    check("noop_in_ready", 64'(in_ready), 64'd1);
    check("noop_no_req", 64'(mem_req), 64'd0);

    // Asynchronous reset while the request is pending discards the operation.
    issue(1, 0, 1, 3'b011, 32'h200, 64'h0, 5'd19);
    @(negedge clk);
    check("rst_mid_req_before", 64'(mem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_mem_req", 64'(mem_req), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    check("rst_mid_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("rst_stale_rv_in_ready", 64'(in_ready), 64'd1);

    run_op("ld_after_rst", 1, 0, 1, 3'b011, 32'h200, 64'h0, 5'd20, 32'h2, 32'h8,
           64'h8877665544332211, 64'h8877665544332211, FAULT_NONE, 4, 8'hFF, 64'h0);

    @(negedge clk);
    @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit for the RV64 pipeline. It sits between EX and WB and is the consumer of the decoder's `mem_read` / `mem_write` / `mem_to_reg` controls. It takes one memory operation at a time and runs it on a request/grant/response data-memory bus. It returns aligned, sign- or zero-extended load data, or a fault, to writeback.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of the data bus.
- TIMEOUT, 255, maximum cycles from grant to response; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX presents an operation.
- in_ready  out  1  unit can accept; high only in IDLE.
- in_mem_read  in  1  load control.
- in_mem_write  in  1  store control.
- in_mem_to_reg  in  1  load result goes to rd.
- in_funct3  in  3  access size and sign.
- in_addr  in  ADDR_W  effective byte address.
- in_wdata  in  64  store data from rs2, right-aligned.
- in_rd  in  5  destination register.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = store.
- mem_addr  out  ADDR_W  doubleword-aligned address.
- mem_be  out  8  byte enables.
- mem_wdata  out  64  lane-shifted store data.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  response; stores also receive a response.
- mem_rdata  in  64  load data.
- wb_valid  out  1  one-cycle result pulse.
- wb_data  out  64  extended load data; 0 for stores and faults.
- wb_rd  out  5  destination register.
- wb_we  out  1  in_mem_to_reg registered at accept, gated off on fault.
- wb_fault  out  2  00 none, 01 misaligned, 10 illegal, 11 timeout.
- busy  out  1  stall to the pipeline; equals ~in_ready.

## Operation
- Accept happens when in_valid & in_ready and exactly one of in_mem_read / in_mem_write is set. The operation is latched at accept.
  - If neither flag is set, the input is ignored and no state changes.
  - If both flags are set, the result is a fault 10.
- funct3 decoding:
  - Loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU. 111 is illegal (fault 10).
  - Stores: 000 SB, 001 SH, 010 SW, 011 SD. 1xx is illegal (fault 10).
- Alignment check: the offset is addr[2:0]. Size 2 needs off[0]=0, size 4 needs off[1:0]=0, size 8 needs off=0. A violation produces fault 01.
- Bus signals:
  - mem_addr = {addr[ADDR_W-1:3], 3'b0}.
  - mem_be = ((1<<size)-1) << off.
  - mem_wdata = in_wdata << (8*off).
- Load data: rdata >> (8*off), truncated to the access size, then sign-extended (funct3[2]=0) or zero-extended (funct3[2]=1) to 64 bits.
- Faulted operations never assert mem_req.

States:
- IDLE: in_ready=1. Valid accept goes to REQ, or to DONE with a fault if the operation is illegal or misaligned.
- REQ: mem_req=1, bus outputs stable. Moves to WAIT on mem_gnt.
- WAIT: the timeout counter runs. Moves to DONE on mem_rvalid; if the counter reaches TIMEOUT first, moves to DONE with fault 11.
- DONE: wb_valid=1 for exactly one cycle, then returns to IDLE.

Rules:
- mem_rvalid is ignored in IDLE, REQ and DONE. A stale response after reset or timeout is dropped.
- The timeout counter is cleared on entry to WAIT and is 0 when TIMEOUT=0.

## Timing
Reset values: in_ready=1, busy=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, wb_valid=0, wb_data=0, wb_rd=0, wb_we=0, wb_fault=00, state IDLE, counter 0.

Latency:
- Accept in cycle 0; mem_req in cycle 1.
- With grant in cycle 1 and rvalid earliest in cycle 2, wb_valid appears in cycle 3.
- Fault path: wb_valid in cycle 1.

Boundary behaviour:
- REQ holds indefinitely without mem_gnt; outputs stay stable and no timeout applies in REQ.
- rvalid in the same cycle as gnt is not seen; the response must come at least one cycle later.
- rvalid in the cycle the counter hits TIMEOUT: rvalid wins, no fault.
- Asynchronous reset mid-transaction: mem_req drops immediately and the operation is discarded.

## Structure
- rv_pkg holds:
  - The funct3 load/store enums.
  - The lsu_state_t enum {IDLE, REQ, WAIT, DONE}.
  - The fault-code localparams (FAULT_NONE, FAULT_MISALIGN, FAULT_ILLEGAL, FAULT_TIMEOUT).
  - The opcode constants shared with the decoder.
- Sub-module lsu_align (combinational) computes byte enables, store shift and load extract/extend. The FSM, counter and registers live in the top module.

## Test plan
- LD at 0x100, gnt in cycle 1, rvalid in cycle 3 with rdata=0x1122334455667788 -> wb_valid in cycle 4, wb_data=0x1122334455667788, mem_be=0xFF.
- LB at 0x103 with rdata byte3=0x80 -> wb_data=0xFFFFFFFFFFFFFF80; the same access as LBU -> 0x80.
- SH at 0x106 with wdata=0xBEEF -> mem_be=0xC0, mem_wdata=0xBEEF000000000000, mem_we=1; wb_valid with wb_we=0.
- LW at 0x102 -> no mem_req; wb_valid in cycle 1, wb_fault=01. Load with funct3=111 -> wb_fault=10.
- TIMEOUT=4, grant given but no rvalid -> wb_fault=11 after 4 WAIT cycles; a late rvalid is ignored and in_ready returns to 1.
- rst_n asserted while in REQ -> mem_req=0 and in_ready=1 immediately. Then an LD issued after release completes normally.
